wb_debug_master: RTL and testbench

Wishbone initiator driven by a byte-stream command link: host-side bytes arrive from a UART receiver, are parsed into single 32-bit read/write transactions, and are issued on a Wishbone master port. Response bytes go back through a UART transmitter. The block sits as an extra master on the system arbiter, alongside the CPU's IF/data masters, and is used for loading and inspecting BaseRAM/ExtRAM and poking the UART window without CPU involvement.

---
 rtl/wb_debug_pkg.sv | 18 +
 rtl/wb_debug_master.sv | 176 +++++++++++++++++
 tb/tb_wb_debug_master.sv | 339 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_debug_pkg.sv
// rtl/wb_debug_pkg.sv - FSM states and command/response byte codes for wb_debug_master
package wb_debug_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ADDR = 3'd1,
        DATA = 3'd2,
        BUS  = 3'd3,
        RESP = 3'd4
    } wb_dbg_state_e;

    localparam logic [7:0] OP_WRITE = 8'h57;
    localparam logic [7:0] OP_READ  = 8'h52;
    localparam logic [7:0] RSP_OK   = 8'h4B;
    localparam logic [7:0] RSP_ERR  = 8'h45;
    localparam logic [7:0] RSP_BAD  = 8'h3F;

endpackage

// File: rtl/wb_debug_master.sv
// rtl/wb_debug_master.sv - byte-command Wishbone initiator; WB_DBG_TIMEOUT_EN enables the bus abort counter
module wb_debug_master
    import wb_debug_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [7:0]            rx_data_i,
    input  logic                  rx_valid_i,
    output logic                  rx_ready_o,
    output logic [7:0]            tx_data_o,
    output logic                  tx_valid_o,
    input  logic                  tx_ready_i,
    output logic                  wb_cyc_o,
    output logic                  wb_stb_o,
    input  logic                  wb_ack_i,
    output logic [ADDR_WIDTH-1:0] wb_adr_o,
    output logic [DATA_WIDTH-1:0] wb_dat_o,
    input  logic [DATA_WIDTH-1:0] wb_dat_i,
    output logic [3:0]            wb_sel_o,
    output logic                  wb_we_o
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    wb_dbg_state_e         state_q, state_d;
    logic [1:0]            cnt_q;
    logic                  op_write_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [7:0]            resp_code_q;
    logic                  resp_multi_q;
    logic                  rx_fire;
    logic                  tx_fire;
    logic                  tmo_hit;

    assign rx_fire = rx_valid_i & rx_ready_o;
    assign tx_fire = tx_valid_o & tx_ready_i;

`ifdef WB_DBG_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [TMO_W-1:0] tmo_cnt_q;

    // Held at zero outside BUS so every bus cycle starts a fresh count.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tmo_cnt_q <= '0;
        end else if (state_q != BUS) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
        end
    end

    assign tmo_hit = (state_q == BUS) && (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (rx_fire) begin
                    state_d = (rx_data_i == OP_WRITE || rx_data_i == OP_READ) ? ADDR : RESP;
                end
            end
            ADDR: begin
                if (rx_fire && cnt_q == 2'd3) begin
                    state_d = op_write_q ? DATA : BUS;
                end
            end
            DATA: begin
                if (rx_fire && cnt_q == 2'd3) begin
                    state_d = BUS;
                end
            end
            BUS: begin
                if (wb_ack_i || tmo_hit) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (tx_fire && (!resp_multi_q || cnt_q == 2'd3)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rx_ready_o = rst_ni && (state_q == IDLE || state_q == ADDR || state_q == DATA);
        wb_cyc_o   = (state_q == BUS);
        wb_stb_o   = (state_q == BUS);
        wb_sel_o   = (state_q == BUS) ? 4'hF : 4'h0;
        wb_we_o    = (state_q == BUS) && op_write_q;
        tx_valid_o = (state_q == RESP);
        tx_data_o  = 8'h00;
        if (state_q == RESP) begin
            tx_data_o = resp_multi_q ? rdata_q[8*cnt_q +: 8] : resp_code_q;
        end
    end

    assign wb_adr_o = addr_q;
    assign wb_dat_o = data_q;

    // cnt_q wraps 3->0 at the end of each phase, so ADDR, DATA and RESP always start from byte 0.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q        <= 2'd0;
            op_write_q   <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            rdata_q      <= '0;
            resp_code_q  <= 8'h00;
            resp_multi_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (rx_fire) begin
                        op_write_q   <= (rx_data_i == OP_WRITE);
                        cnt_q        <= 2'd0;
                        resp_code_q  <= RSP_BAD;
                        resp_multi_q <= 1'b0;
                    end
                end
                ADDR: begin
                    if (rx_fire) begin
                        addr_q <= {rx_data_i, addr_q[ADDR_WIDTH-1:8]};
                        cnt_q  <= cnt_q + 2'd1;
                    end
                end
                DATA: begin
                    if (rx_fire) begin
                        data_q <= {rx_data_i, data_q[DATA_WIDTH-1:8]};
                        cnt_q  <= cnt_q + 2'd1;
                    end
                end
                BUS: begin
                    if (wb_ack_i) begin
                        rdata_q      <= wb_dat_i;
                        resp_code_q  <= RSP_OK;
                        resp_multi_q <= !op_write_q;
                        cnt_q        <= 2'd0;
                    end else if (tmo_hit) begin
                        resp_code_q  <= RSP_ERR;
                        resp_multi_q <= 1'b0;
                        cnt_q        <= 2'd0;
                    end
                end
                RESP: begin
                    if (tx_fire) begin
                        cnt_q <= cnt_q + 2'd1;
                    end
                end
                default: cnt_q <= 2'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_debug_master.sv
// tb/tb_wb_debug_master.sv - self-checking bench for wb_debug_master against a transaction-level model
module tb_wb_debug_master;

    localparam int TMO = 16;

    typedef struct {
        logic [31:0] adr;
        logic [31:0] dat;
        logic        we;
    } bus_t;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [7:0]  rx_data_i;
    logic        rx_valid_i;
    logic        rx_ready_o;
    logic [7:0]  tx_data_o;
    logic        tx_valid_o;
    logic        tx_ready_i;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_ack_i;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o;

    bus_t        exp_bus[$];
    logic [7:0]  exp_tx[$];
    int          tests = 0;
    int          fails = 0;
    int          gap_max = 0;
    int          slave_wait = 0;
    logic        slave_noack = 1'b0;
    logic [31:0] slave_rdata = 32'h0;

    wb_debug_master #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .rx_data_i  (rx_data_i),
        .rx_valid_i (rx_valid_i),
        .rx_ready_o (rx_ready_o),
        .tx_data_o  (tx_data_o),
        .tx_valid_o (tx_valid_o),
        .tx_ready_i (tx_ready_i),
        .wb_cyc_o   (wb_cyc_o),
        .wb_stb_o   (wb_stb_o),
        .wb_ack_i   (wb_ack_i),
        .wb_adr_o   (wb_adr_o),
        .wb_dat_o   (wb_dat_o),
        .wb_dat_i   (wb_dat_i),
        .wb_sel_o   (wb_sel_o),
        .wb_we_o    (wb_we_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        tests++;
        fails++;
        $display("FAIL %s", name);
    endtask

    // Called at a negedge; returns at the negedge after the byte was taken.
    task automatic send_byte(input logic [7:0] b);
        int n;
        repeat ($urandom_range(0, gap_max)) @(negedge clk_i);
        rx_data_i  = b;
        rx_valid_i = 1'b1;
        n = 0;
        while (!rx_ready_o && n < 500) begin
            @(negedge clk_i);
            n++;
        end
        if (n >= 500) flag("rx_accept_timeout");
        @(negedge clk_i);
        rx_valid_i = 1'b0;
    endtask

    task automatic send_cmd(input logic [7:0] op, input logic [31:0] a, input logic [31:0] d);
        send_byte(op);
        for (int k = 0; k < 4; k++) send_byte(a[8*k +: 8]);
        if (op == 8'h57) begin
            for (int k = 0; k < 4; k++) send_byte(d[8*k +: 8]);
        end
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d);
        exp_bus.push_back('{a, d, 1'b1});
        exp_tx.push_back(8'h4B);
        send_cmd(8'h57, a, d);
    endtask

    task automatic do_read(input logic [31:0] a, input logic [31:0] rd);
        slave_rdata = rd;
        exp_bus.push_back('{a, 32'h0, 1'b0});
        for (int k = 0; k < 4; k++) exp_tx.push_back(rd[8*k +: 8]);
        send_cmd(8'h52, a, 32'h0);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_tx.size() != 0 || exp_bus.size() != 0 || tx_valid_o || wb_cyc_o) && n < 2000) begin
            @(negedge clk_i);
            n++;
        end
        check("idle_reached", 32'(n < 2000), 32'd1);
    endtask

    // Slave: acks slave_wait cycles after cyc is seen, one-cycle ack pulse.
    initial begin
        int scnt;
        scnt     = 0;
        wb_ack_i = 1'b0;
        wb_dat_i = 32'h0;
        forever begin
            @(negedge clk_i);
            if (!rst_ni || !wb_cyc_o || wb_ack_i) begin
                wb_ack_i = 1'b0;
                scnt     = 0;
            end else if (!slave_noack) begin
                if (scnt >= slave_wait) begin
                    wb_ack_i = 1'b1;
                    wb_dat_i = slave_rdata;
                end else begin
                    scnt++;
                end
            end
        end
    end

    // Compare process: bus cycles and tx bytes against the model queues.
    initial begin
        bus_t       cur;
        logic       cyc_prev;
        logic       held;
        logic [7:0] held_data;
        logic [7:0] e;
        cyc_prev  = 1'b0;
        held      = 1'b0;
        held_data = 8'h0;
        cur       = '{32'h0, 32'h0, 1'b0};
        forever begin
            @(negedge clk_i);
            #1;
            if (!rst_ni) begin
                cyc_prev = 1'b0;
                held     = 1'b0;
            end else begin
                if (wb_cyc_o && !cyc_prev) begin
                    if (exp_bus.size() == 0) begin
                        flag("bus_unexpected");
                        cur = '{wb_adr_o, wb_dat_o, wb_we_o};
                    end else begin
                        cur = exp_bus.pop_front();
                        check("bus_adr", wb_adr_o, cur.adr);
                        check("bus_we", 32'(wb_we_o), 32'(cur.we));
                        if (cur.we) check("bus_dat", wb_dat_o, cur.dat);
                    end
                end
                if (wb_cyc_o) begin
                    check("bus_stb", 32'(wb_stb_o), 32'd1);
                    check("bus_sel", 32'(wb_sel_o), 32'hF);
                    if (cyc_prev) begin
                        check("bus_adr_stable", wb_adr_o, cur.adr);
                        check("bus_we_stable", 32'(wb_we_o), 32'(cur.we));
                    end
                end else begin
                    check("bus_idle_outputs", {29'd0, wb_stb_o, wb_we_o, |wb_sel_o}, 32'd0);
                end
                if (tx_valid_o) begin
                    if (held) check("tx_hold_data", 32'(tx_data_o), 32'(held_data));
                    if (tx_ready_i) begin
                        held = 1'b0;
                        if (exp_tx.size() == 0) begin
                            flag("tx_unexpected");
                        end else begin
                            e = exp_tx.pop_front();
                            check("tx_byte", 32'(tx_data_o), 32'(e));
                        end
                    end else begin
                        held      = 1'b1;
                        held_data = tx_data_o;
                    end
                end else if (held) begin
                    flag("tx_dropped");
                    held = 1'b0;
                end
                if (rx_ready_o && (wb_cyc_o || tx_valid_o)) flag("rx_ready_while_busy");
                cyc_prev = wb_cyc_o;
            end
        end
    end

    initial begin
        int n;
        rst_ni     = 1'b0;
        rx_data_i  = 8'h00;
        rx_valid_i = 1'b0;
        tx_ready_i = 1'b1;

        repeat (3) @(negedge clk_i);
        check("rst_rx_ready", 32'(rx_ready_o), 32'd0);
        check("rst_cyc_stb", {30'd0, wb_cyc_o, wb_stb_o}, 32'd0);
        check("rst_tx", {23'd0, tx_valid_o, tx_data_o}, 32'd0);
        check("rst_sel_we", {27'd0, wb_sel_o, wb_we_o}, 32'd0);
        check("rst_adr", wb_adr_o, 32'd0);
        check("rst_dat", wb_dat_o, 32'd0);
        rst_ni = 1'b1;
        repeat (2) @(negedge clk_i);
        check("idle_rx_ready", 32'(rx_ready_o), 32'd1);

        // Write, zero-wait slave: cyc right after the last byte, 'K' the cycle after.
        slave_wait = 0;
        do_write(32'h8000_0000, 32'hDEAD_BEEF);
        check("lat_cyc", 32'(wb_cyc_o), 32'd1);
        check("lit_wr_adr", wb_adr_o, 32'h8000_0000);
        check("lit_wr_dat", wb_dat_o, 32'hDEAD_BEEF);
        @(negedge clk_i);
        check("lat_cyc_fall", 32'(wb_cyc_o), 32'd0);
        check("lat_k_valid", 32'(tx_valid_o), 32'd1);
        check("lit_k", 32'(tx_data_o), 32'h4B);
        wait_idle();

        do_read(32'h8040_0004, 32'h1234_5678);
        check("lit_rd_adr", wb_adr_o, 32'h8040_0004);
        check("lit_rd_we", 32'(wb_we_o), 32'd0);
        wait_idle();

        exp_tx.push_back(8'h3F);
        send_byte(8'h00);
        check("lit_bad_valid", 32'(tx_valid_o), 32'd1);
        check("lit_bad_byte", 32'(tx_data_o), 32'h3F);
        check("lit_bad_nocyc", 32'(wb_cyc_o), 32'd0);
        wait_idle();

        // Transmitter stalled for 5 cycles on the first read byte.
        tx_ready_i = 1'b0;
        slave_wait = 2;
        do_read(32'h0000_0010, 32'hA1B2_C3D4);
        n = 0;
        while (!tx_valid_o && n < 100) begin
            @(negedge clk_i);
            n++;
        end
        check("hold_seen", 32'(tx_valid_o), 32'd1);
        repeat (5) @(negedge clk_i);
        check("lit_hold_valid", 32'(tx_valid_o), 32'd1);
        check("lit_hold_byte", 32'(tx_data_o), 32'hD4);
        tx_ready_i = 1'b1;
        wait_idle();

        // Random rx gaps and slave waits, including unaligned addresses.
        gap_max = 3;
        do_write(32'h8000_0000, 32'hDEAD_BEEF);
        wait_idle();
        for (int i = 0; i < 4; i++) begin
            slave_wait = $urandom_range(0, 3);
            do_write(32'h1000_0001 + 32'(i) * 32'h100, $urandom);
            wait_idle();
            slave_wait = $urandom_range(0, 3);
            do_read(32'h2000_0000 + 32'(i), $urandom);
            wait_idle();
        end
        gap_max    = 0;
        slave_wait = 0;

`ifdef WB_DBG_TIMEOUT_EN
        slave_noack = 1'b1;
        exp_bus.push_back('{32'h2000_0040, 32'h0, 1'b0});
        exp_tx.push_back(8'h45);
        send_cmd(8'h52, 32'h2000_0040, 32'h0);
        n = 0;
        while (wb_cyc_o && n < 200) begin
            n++;
            @(negedge clk_i);
        end
        check("tmo_cyc_len", 32'(n), 32'(TMO));
        check("lit_tmo_valid", 32'(tx_valid_o), 32'd1);
        check("lit_tmo_byte", 32'(tx_data_o), 32'h45);
        slave_noack = 1'b0;
        wait_idle();
        do_write(32'h3000_0000, 32'h0BAD_F00D);
        wait_idle();
        slave_noack = 1'b1;
        exp_bus.push_back('{32'h8000_0100, 32'h5A5A_5A5A, 1'b1});
        send_cmd(8'h57, 32'h8000_0100, 32'h5A5A_5A5A);
`else
        slave_noack = 1'b1;
        exp_bus.push_back('{32'h2000_0040, 32'h0, 1'b0});
        send_cmd(8'h52, 32'h2000_0040, 32'h0);
        repeat (40) @(negedge clk_i);
        check("no_tmo_cyc_high", 32'(wb_cyc_o), 32'd1);
        check("no_tmo_no_tx", 32'(tx_valid_o), 32'd0);
`endif

        // Reset in the middle of a bus cycle.
        @(negedge clk_i);
        check("pre_rst_cyc", 32'(wb_cyc_o), 32'd1);
        #2;
        rst_ni = 1'b0;
        #1;
        check("mid_rst_cyc_stb", {30'd0, wb_cyc_o, wb_stb_o}, 32'd0);
        check("mid_rst_tx_valid", 32'(tx_valid_o), 32'd0);
        check("mid_rst_rx_ready", 32'(rx_ready_o), 32'd0);
        exp_tx.delete();
        exp_bus.delete();
        slave_noack = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        do_write(32'h8000_0200, 32'hCAFE_F00D);
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1, "global timeout");
    end

endmodule
